noc_link_buffer: RTL and testbench
==================================

// Module: noc_link_buffer
// PURPOSE
//   Credit-terminating buffered link between one router output port and the next router's input port.
//   Absorbs upstream flits (send/credit) into a local FIFO and re-issues them downstream under its own
//   credit counter. Optional retiming stages on the forward path give long inter-router wires slack
//   without changing the flit protocol on either side.
// PARAMETERS
//   FLIT_WIDTH          32  flit payload width
//   DEST_WIDTH          4   destination field width (TDEST_WIDTH + TID_WIDTH)
//   LINK_BUFFER_DEPTH   4   FIFO entries (>=2); upstream router must own exactly this many credits
//   DOWNSTREAM_CREDITS  1   initial credit count, equal to downstream FLIT_BUFFER_DEPTH (>=1)
//   FWD_PIPELINE        0   extra register stages on send/data/dest/is_tail out (0..4)
// PORTS
//   clk_noc      in   1           NoC clock
//   rst_n        in   1           asynchronous active-low reset
//   data_in      in   FLIT_WIDTH  flit payload from upstream router
//   dest_in      in   DEST_WIDTH  flit destination
//   is_tail_in   in   1           last flit of packet
//   send_in      in   1           flit valid, one cycle per flit
//   credit_out   out  1           one-cycle pulse per freed FIFO entry, to upstream
//   data_out     out  FLIT_WIDTH  flit payload to downstream router
//   dest_out     out  DEST_WIDTH  flit destination
//   is_tail_out  out  1           last flit of packet
//   send_out     out  1           flit valid, one cycle per flit
//   credit_in    in   1           one-cycle pulse per credit returned by downstream
//   err_overflow out  1           sticky: flit arrived with FIFO full, or credit counter overflow
// BEHAVIOUR
//   - Reset (rst_n low, async): FIFO empty, pointers 0, credit count = DOWNSTREAM_CREDITS, all pipeline
//     stages cleared; send_out, credit_out, is_tail_out, err_overflow = 0; data_out, dest_out = 0.
//   - Push: send_in=1 writes {data,dest,is_tail} at wr_ptr. Accepted when not full, or when full and a pop
//     occurs the same cycle (count unchanged).
//   - Pop: asserted in any cycle with FIFO non-empty and credit count > 0. A credit_in arriving in the
//     same cycle is not usable until the next cycle.
//   - Credit count: next = count - pop + credit_in. If the result would exceed DOWNSTREAM_CREDITS it
//     saturates at DOWNSTREAM_CREDITS and err_overflow is set.
//   - Popped flit is registered into stage 0; send_out is the output of the final stage
//     (stage 0 + FWD_PIPELINE registers). All stages update every cycle; send=0 bubbles propagate.
//   - credit_out is registered and pulses 1 cycle after each pop; it never pulses for dropped flits.
//   - Latency send_in -> send_out with an empty FIFO and credits available: 2 + FWD_PIPELINE cycles.
//   - Throughput: 1 flit/cycle sustained when DOWNSTREAM_CREDITS >= round-trip to the downstream buffer.
//   - Overflow: send_in with FIFO full and no pop -> flit dropped, FIFO unchanged, err_overflow set.
//     err_overflow clears only on reset.
//   - Pointers wrap modulo LINK_BUFFER_DEPTH. Occupancy counter width is $clog2(LINK_BUFFER_DEPTH+1).
//   - Flit order is preserved. is_tail has no effect on flow control.
//   - Reset mid-packet: in-flight and buffered flits are discarded; both neighbours must be reset together.
// CONFIGURATION
//   NOC_LINK_STATS_EN defined: adds outputs
//     stat_flits  out 32  wrapping count of flits popped
//     stat_pkts   out 32  wrapping count of popped flits with is_tail = 1
//     stat_stall  out 32  cycles with FIFO non-empty and credit count = 0
//   All three counters reset to 0. NOC_LINK_STATS_EN undefined: these ports and counters do not exist.
//   Core behaviour is identical in both builds.
// TESTING
//   1. Reset, defaults. Single flit data=0xDEADBEEF, dest=4'h5, tail=1.
//      -> send_out 2 cycles later with the same fields; credit_out pulses 1 cycle after the pop.
//   2. DOWNSTREAM_CREDITS=1, no credit_in. Send 3 flits back-to-back.
//      -> exactly 1 send_out; FIFO holds 2. Each later credit_in pulse releases 1 flit, in order.
//   3. LINK_BUFFER_DEPTH=4, credits withheld. Send 6 flits.
//      -> 1 flit forwarded, 4 buffered, 6th dropped; err_overflow = 1 from the cycle after the 6th flit.
//   4. Same-cycle push and pop with FIFO full.
//      -> push accepted, err_overflow stays 0, occupancy unchanged.
//   5. FWD_PIPELINE=3, stream of 100 flits with random credit_in returns (no credit overflow).
//      -> all 100 flits arrive in order, 5-cycle minimum latency, 100 credit_out pulses.
//   6. Assert rst_n low mid-stream with 3 flits buffered.
//      -> all outputs 0 immediately (async); after release, credit count = DOWNSTREAM_CREDITS and FIFO empty.
//      With NOC_LINK_STATS_EN: stat_flits and stat_pkts match the scoreboard before reset and read 0 after.

Source files
------------

// File: rtl/noc_link_buffer.sv
// Buffered NoC link: absorbs upstream flits into a local FIFO and re-issues them downstream on its own credits.
// Latency: send_in -> send_out is 2 + FWD_PIPELINE cycles with an empty FIFO and credits available.
// Backpressure: upstream via credit_out pulses (one per pop); downstream via credit_in; optional stats with NOC_LINK_STATS_EN.
module noc_link_buffer #(
    parameter int FLIT_WIDTH         = 32,
    parameter int DEST_WIDTH         = 4,
    parameter int LINK_BUFFER_DEPTH  = 4,
    parameter int DOWNSTREAM_CREDITS = 1,
    parameter int FWD_PIPELINE       = 0
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic                  err_overflow
`ifdef NOC_LINK_STATS_EN
    ,
    output logic [31:0]           stat_flits,
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_stall
`endif
);

    localparam int PTR_W = $clog2(LINK_BUFFER_DEPTH);
    localparam int OCC_W = $clog2(LINK_BUFFER_DEPTH + 1);
    localparam int CRD_W = $clog2(DOWNSTREAM_CREDITS + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINK_BUFFER_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(LINK_BUFFER_DEPTH);
    localparam logic [CRD_W-1:0] CRD_INIT = CRD_W'(DOWNSTREAM_CREDITS);
    localparam logic [CRD_W:0]   CRD_MAX  = (CRD_W + 1)'(DOWNSTREAM_CREDITS);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } flit_t;

    flit_t                    mem [LINK_BUFFER_DEPTH];
    flit_t                    flit_in;
    flit_t                    head;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [OCC_W-1:0]         occ;
    logic [CRD_W-1:0]         crd_cnt;
    logic [CRD_W:0]           crd_sum;
    logic                     empty;
    logic                     full;
    logic                     pop;
    logic                     push;
    logic                     drop;
    logic                     crd_ovf;
    logic [FWD_PIPELINE:0]    stg_vld;
    flit_t [FWD_PIPELINE:0]   stg_flit;

    assign flit_in = '{data: data_in, dest: dest_in, tail: is_tail_in};
    assign head    = mem[rd_ptr];
    assign empty   = (occ == '0);
    assign full    = (occ == OCC_FULL);

    // A credit arriving this cycle only becomes spendable next cycle, so pop looks at the registered count.
    assign pop     = !empty && (crd_cnt != '0);
    // When full, a simultaneous pop frees the slot being written, so the flit is still accepted.
    assign push    = send_in && (!full || pop);
    assign drop    = send_in && full && !pop;

    // The count never exceeds CRD_MAX, so one extra bit holds the worst-case +1 before saturation.
    assign crd_sum = {1'b0, crd_cnt} - {{CRD_W{1'b0}}, pop} + {{CRD_W{1'b0}}, credit_in};
    assign crd_ovf = (crd_sum > CRD_MAX);

    // Flit storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_noc) begin
        if (push) begin
            mem[wr_ptr] <= flit_in;
        end
    end

    // Pointers, occupancy, downstream credit count and the sticky error flag.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            crd_cnt      <= CRD_INIT;
            credit_out   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            crd_cnt      <= crd_ovf ? CRD_INIT : crd_sum[CRD_W-1:0];
            credit_out   <= pop;
            err_overflow <= err_overflow | drop | crd_ovf;
        end
    end

    // Forward retiming chain: stage 0 captures the popped flit, bubbles are zeroed and shift along.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld  <= '0;
            stg_flit <= '0;
        end else begin
            stg_vld[0]  <= pop;
            stg_flit[0] <= pop ? head : '0;
            for (int i = 1; i <= FWD_PIPELINE; i++) begin
                stg_vld[i]  <= stg_vld[i-1];
                stg_flit[i] <= stg_flit[i-1];
            end
        end
    end

    assign send_out    = stg_vld[FWD_PIPELINE];
    assign data_out    = stg_flit[FWD_PIPELINE].data;
    assign dest_out    = stg_flit[FWD_PIPELINE].dest;
    assign is_tail_out = stg_flit[FWD_PIPELINE].tail;

`ifdef NOC_LINK_STATS_EN
    // Wrapping statistics: flits and tails leaving the FIFO, and cycles blocked on downstream credit.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            stat_flits <= '0;
            stat_pkts  <= '0;
            stat_stall <= '0;
        end else begin
            stat_flits <= stat_flits + 32'(pop);
            stat_pkts  <= stat_pkts + 32'(pop && head.tail);
            stat_stall <= stat_stall + 32'(!empty && (crd_cnt == '0));
        end
    end
`endif

endmodule

// File: tb/tb_noc_link_buffer.sv
// Directed bench for noc_link_buffer: DUT a uses defaults, DUT b uses FWD_PIPELINE=3 and 4 downstream credits.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at that same point.
// Each scenario task does its own comparisons; the summary line reports checks and errors.
module tb_noc_link_buffer;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] a_data_in, a_data_out;
    logic [3:0]  a_dest_in, a_dest_out;
    logic        a_tail_in, a_tail_out, a_send_in, a_send_out;
    logic        a_credit_in, a_credit_out, a_err;

    logic [31:0] b_data_in, b_data_out;
    logic [3:0]  b_dest_in, b_dest_out;
    logic        b_tail_in, b_tail_out, b_send_in, b_send_out;
    logic        b_credit_in, b_credit_out, b_err;

`ifdef NOC_LINK_STATS_EN
    logic [31:0] a_stat_flits, a_stat_pkts, a_stat_stall;
    logic [31:0] b_stat_flits, b_stat_pkts, b_stat_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    noc_link_buffer u_dut_a (
        .clk_noc      (clk),
        .rst_n        (rst_n),
        .data_in      (a_data_in),
        .dest_in      (a_dest_in),
        .is_tail_in   (a_tail_in),
        .send_in      (a_send_in),
        .credit_out   (a_credit_out),
        .data_out     (a_data_out),
        .dest_out     (a_dest_out),
        .is_tail_out  (a_tail_out),
        .send_out     (a_send_out),
        .credit_in    (a_credit_in),
        .err_overflow (a_err)
`ifdef NOC_LINK_STATS_EN
        ,
        .stat_flits   (a_stat_flits),
        .stat_pkts    (a_stat_pkts),
        .stat_stall   (a_stat_stall)
`endif
    );

    noc_link_buffer #(
        .DOWNSTREAM_CREDITS (4),
        .FWD_PIPELINE       (3)
    ) u_dut_b (
        .clk_noc      (clk),
        .rst_n        (rst_n),
        .data_in      (b_data_in),
        .dest_in      (b_dest_in),
        .is_tail_in   (b_tail_in),
        .send_in      (b_send_in),
        .credit_out   (b_credit_out),
        .data_out     (b_data_out),
        .dest_out     (b_dest_out),
        .is_tail_out  (b_tail_out),
        .send_out     (b_send_out),
        .credit_in    (b_credit_in),
        .err_overflow (b_err)
`ifdef NOC_LINK_STATS_EN
        ,
        .stat_flits   (b_stat_flits),
        .stat_pkts    (b_stat_pkts),
        .stat_stall   (b_stat_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        a_data_in = '0; a_dest_in = '0; a_tail_in = 1'b0; a_send_in = 1'b0; a_credit_in = 1'b0;
        b_data_in = '0; b_dest_in = '0; b_tail_in = 1'b0; b_send_in = 1'b0; b_credit_in = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_a(input logic [31:0] d, input logic [3:0] de, input logic t);
        a_data_in = d; a_dest_in = de; a_tail_in = t; a_send_in = 1'b1;
    endtask

    task automatic pulse_credit_a();
        a_credit_in = 1'b1;
        tick();
        a_credit_in = 1'b0;
    endtask

    // Waits up to budget cycles for a flit on DUT a and returns its payload.
    task automatic wait_flit_a(input int budget, output bit got, output logic [31:0] d);
        got = 1'b0;
        d   = '0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (a_send_out) begin
                got = 1'b1;
                d   = a_data_out;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({a_send_out, a_credit_out, a_tail_out, a_err, a_data_out, a_dest_out} !== '0) begin
            errors++;
            $display("FAIL reset_a outputs got send=%0b cr=%0b tail=%0b err=%0b data=%h dest=%h exp all 0",
                     a_send_out, a_credit_out, a_tail_out, a_err, a_data_out, a_dest_out);
        end
        checks++;
        if ({b_send_out, b_credit_out, b_tail_out, b_err, b_data_out, b_dest_out} !== '0) begin
            errors++;
            $display("FAIL reset_b outputs got send=%0b cr=%0b err=%0b data=%h exp all 0",
                     b_send_out, b_credit_out, b_err, b_data_out);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_flit();
        apply_reset();
        drive_a(32'hDEADBEEF, 4'h5, 1'b1);
        tick();
        idle_inputs();
        checks++;
        if (a_send_out !== 1'b0 || a_credit_out !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle1 got send=%0b credit=%0b exp 0 0", a_send_out, a_credit_out);
        end
        tick();
        checks++;
        if (a_send_out !== 1'b1 || a_data_out !== 32'hDEADBEEF || a_dest_out !== 4'h5 || a_tail_out !== 1'b1) begin
            errors++;
            $display("FAIL single_flit got send=%0b data=%h dest=%h tail=%0b exp 1 deadbeef 5 1",
                     a_send_out, a_data_out, a_dest_out, a_tail_out);
        end
        checks++;
        if (a_credit_out !== 1'b1) begin
            errors++;
            $display("FAIL single_credit_out got %0b exp 1", a_credit_out);
        end
        tick();
        checks++;
        if (a_send_out !== 1'b0 || a_credit_out !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width got send=%0b credit=%0b exp 0 0", a_send_out, a_credit_out);
        end
    endtask

    task automatic test_back_to_back();
        int          n_out;
        logic [31:0] first;
        bit          got;
        logic [31:0] d;
        apply_reset();
        n_out = 0;
        first = '0;
        for (int i = 0; i < 3; i++) begin
            drive_a(32'h1000 + 32'(i), 4'(i), i == 2);
            tick();
            if (a_send_out) begin
                if (n_out == 0) first = a_data_out;
                n_out++;
            end
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_send_out) begin
                if (n_out == 0) first = a_data_out;
                n_out++;
            end
        end
        checks++;
        if (n_out != 1 || first !== 32'h1000) begin
            errors++;
            $display("FAIL b2b_first got count=%0d data=%h exp 1 00001000", n_out, first);
        end
        for (int k = 1; k <= 2; k++) begin
            pulse_credit_a();
            wait_flit_a(6, got, d);
            checks++;
            if (!got || d !== 32'h1000 + 32'(k)) begin
                errors++;
                $display("FAIL b2b_release%0d got valid=%0b data=%h exp 1 %h", k, got, d, 32'h1000 + 32'(k));
            end
        end
        pulse_credit_a();
        wait_flit_a(6, got, d);
        checks++;
        if (got) begin
            errors++;
            $display("FAIL b2b_empty got extra flit data=%h exp none", d);
        end
    endtask

    task automatic test_overflow();
        int          n_out;
        bit          got;
        logic [31:0] d;
        apply_reset();
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            drive_a(32'h3000 + 32'(i), 4'(i), 1'b0);
            tick();
            if (a_send_out) n_out++;
            if (i == 4) begin
                checks++;
                if (a_err !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early got err=%0b exp 0", a_err);
                end
            end
        end
        idle_inputs();
        checks++;
        if (a_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got err=%0b exp 1", a_err);
        end
        checks++;
        if (n_out != 1) begin
            errors++;
            $display("FAIL ovf_forwarded got %0d exp 1", n_out);
        end
        for (int k = 1; k <= 4; k++) begin
            pulse_credit_a();
            wait_flit_a(6, got, d);
            checks++;
            if (!got || d !== 32'h3000 + 32'(k)) begin
                errors++;
                $display("FAIL ovf_drain%0d got valid=%0b data=%h exp 1 %h", k, got, d, 32'h3000 + 32'(k));
            end
        end
        pulse_credit_a();
        wait_flit_a(6, got, d);
        checks++;
        if (got) begin
            errors++;
            $display("FAIL ovf_dropped got data=%h exp none", d);
        end
        checks++;
        if (a_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got err=%0b exp 1", a_err);
        end
    endtask

    task automatic test_full_push_pop();
        bit          got;
        logic [31:0] d;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_a(32'h4000 + 32'(i), 4'(i), 1'b0);
            tick();
        end
        idle_inputs();
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL fpp_fill got err=%0b exp 0", a_err);
        end
        pulse_credit_a();
        drive_a(32'h4005, 4'h5, 1'b1);
        tick();
        idle_inputs();
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL fpp_push_pop got err=%0b exp 0", a_err);
        end
        checks++;
        if (a_send_out !== 1'b1 || a_data_out !== 32'h4001) begin
            errors++;
            $display("FAIL fpp_popped got send=%0b data=%h exp 1 00004001", a_send_out, a_data_out);
        end
        // Occupancy must still be full: one more push with no credit is dropped.
        drive_a(32'h4006, 4'h6, 1'b0);
        tick();
        idle_inputs();
        checks++;
        if (a_err !== 1'b1) begin
            errors++;
            $display("FAIL fpp_still_full got err=%0b exp 1", a_err);
        end
        for (int k = 2; k <= 5; k++) begin
            pulse_credit_a();
            wait_flit_a(6, got, d);
            checks++;
            if (!got || d !== 32'h4000 + 32'(k)) begin
                errors++;
                $display("FAIL fpp_drain%0d got valid=%0b data=%h exp 1 %h", k, got, d, 32'h4000 + 32'(k));
            end
        end
        pulse_credit_a();
        wait_flit_a(6, got, d);
        checks++;
        if (got) begin
            errors++;
            $display("FAIL fpp_empty got data=%h exp none", d);
        end
    endtask

    task automatic test_stream();
        int send_cyc [100];
        int sent, rcvd, up_crd, dn_pend, n_cred, min_lat, lat;
        apply_reset();
        sent = 0; rcvd = 0; up_crd = 4; dn_pend = 0; n_cred = 0; min_lat = 1000;
        for (int t = 0; t < 3000 && rcvd < 100; t++) begin
            b_send_in   = 1'b0;
            b_credit_in = 1'b0;
            if (sent < 100 && up_crd > 0) begin
                b_data_in   = 32'hA500_0000 + 32'(sent);
                b_dest_in   = 4'(sent);
                b_tail_in   = (sent % 4 == 3);
                b_send_in   = 1'b1;
                send_cyc[sent] = cyc;
                sent++;
                up_crd--;
            end
            if (dn_pend > 0 && $urandom_range(0, 2) != 0) begin
                b_credit_in = 1'b1;
                dn_pend--;
            end
            tick();
            if (b_credit_out) begin
                up_crd++;
                n_cred++;
            end
            if (b_send_out) begin
                checks++;
                if (rcvd >= 100) begin
                    errors++;
                    $display("FAIL stream_extra got data=%h exp no flit", b_data_out);
                end else begin
                    if (b_data_out !== 32'hA500_0000 + 32'(rcvd) || b_dest_out !== 4'(rcvd) ||
                        b_tail_out !== (rcvd % 4 == 3)) begin
                        errors++;
                        $display("FAIL stream_flit%0d got data=%h dest=%h tail=%0b exp %h %h %0b", rcvd,
                                 b_data_out, b_dest_out, b_tail_out, 32'hA500_0000 + 32'(rcvd),
                                 4'(rcvd), (rcvd % 4 == 3));
                    end
                    lat = cyc - send_cyc[rcvd];
                    if (lat < min_lat) min_lat = lat;
                    rcvd++;
                    dn_pend++;
                end
            end
        end
        idle_inputs();
        checks++;
        if (rcvd != 100) begin
            errors++;
            $display("FAIL stream_count got %0d exp 100", rcvd);
        end
        checks++;
        if (n_cred != 100) begin
            errors++;
            $display("FAIL stream_credits got %0d exp 100", n_cred);
        end
        checks++;
        if (min_lat != 5) begin
            errors++;
            $display("FAIL stream_min_latency got %0d exp 5", min_lat);
        end
        checks++;
        if (b_err !== 1'b0) begin
            errors++;
            $display("FAIL stream_err got %0b exp 0", b_err);
        end
`ifdef NOC_LINK_STATS_EN
        checks++;
        if (b_stat_flits !== 32'd100 || b_stat_pkts !== 32'd25) begin
            errors++;
            $display("FAIL stream_stats got flits=%0d pkts=%0d exp 100 25", b_stat_flits, b_stat_pkts);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit          got;
        logic [31:0] d;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_a(32'h6000 + 32'(i), 4'(i), (i % 2 == 1));
            tick();
        end
        idle_inputs();
        // Release f1, leaving three flits buffered while f1 is on the outputs.
        pulse_credit_a();
        tick();
        checks++;
        if (a_send_out !== 1'b1 || a_credit_out !== 1'b1 || a_data_out !== 32'h6001) begin
            errors++;
            $display("FAIL rmid_pre got send=%0b credit=%0b data=%h exp 1 1 00006001",
                     a_send_out, a_credit_out, a_data_out);
        end
`ifdef NOC_LINK_STATS_EN
        checks++;
        if (a_stat_flits !== 32'd2 || a_stat_pkts !== 32'd1) begin
            errors++;
            $display("FAIL rmid_stats_pre got flits=%0d pkts=%0d exp 2 1", a_stat_flits, a_stat_pkts);
        end
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_send_out, a_credit_out, a_tail_out, a_err, a_data_out, a_dest_out} !== '0) begin
            errors++;
            $display("FAIL rmid_async got send=%0b credit=%0b tail=%0b data=%h dest=%h exp all 0",
                     a_send_out, a_credit_out, a_tail_out, a_data_out, a_dest_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef NOC_LINK_STATS_EN
        checks++;
        if (a_stat_flits !== 32'd0 || a_stat_pkts !== 32'd0) begin
            errors++;
            $display("FAIL rmid_stats_post got flits=%0d pkts=%0d exp 0 0", a_stat_flits, a_stat_pkts);
        end
`endif
        drive_a(32'h6100, 4'hA, 1'b1);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (a_send_out !== 1'b1 || a_data_out !== 32'h6100) begin
            errors++;
            $display("FAIL rmid_credit_restored got send=%0b data=%h exp 1 00006100", a_send_out, a_data_out);
        end
        pulse_credit_a();
        wait_flit_a(6, got, d);
        checks++;
        if (got) begin
            errors++;
            $display("FAIL rmid_fifo_empty got stale data=%h exp none", d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_single_flit();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
